uart_tx_fifo: RTL

//   Byte queue sitting directly upstream of the UART transmitter. It accepts

---
 rtl/uart_tx_fifo_if.sv | 28 ++
 rtl/uart_tx_fifo.sv | 122 ++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_if.sv
// Host-side byte handshake plus transmitter launch/busy signals for uart_tx_fifo.
// master: host logic and transmitter; slave: the FIFO itself.
interface uart_tx_fifo_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] tx_din;
  logic       tx_wr_en;
  logic       tx_busy;

  modport master (
    output in_data,
    output in_valid,
    output tx_busy,
    input  in_ready,
    input  tx_din,
    input  tx_wr_en
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  tx_busy,
    output in_ready,
    output tx_din,
    output tx_wr_en
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter, one launch per idle transmitter.
// UART_TXQ_OVERFLOW_EN adds a sticky overflow flag with ovf_clr.
module uart_tx_fifo #(
  parameter  int unsigned DEPTH  = 16,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_50m,
  input  logic              rst,
  uart_tx_fifo_if.slave     bus,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   level
`ifdef UART_TXQ_OVERFLOW_EN
  ,
  input  logic              ovf_clr,
  output logic              overflow
`endif
);

  localparam logic [ADDR_W:0] LEVEL_FULL = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_GUARD  = 2'd2,
    S_WAIT   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   level_q, level_d;
  logic              empty_q, full_q, in_ready_q, wr_en_q;
  logic [7:0]        tx_din_q;
  logic              push_c, pop_c;

  // in_ready follows registered full, so a push never races a same-edge pop
  assign push_c = bus.in_valid & ~full_q;

  // Drain FSM: pop happens on the IDLE->LAUNCH edge
  always_comb begin
    state_d = state_q;
    pop_c   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty_q && !bus.tx_busy) begin
          state_d = S_LAUNCH;
          pop_c   = 1'b1;
        end
      end
      S_LAUNCH: state_d = S_GUARD;
      S_GUARD:  state_d = S_WAIT;
      S_WAIT:   if (!bus.tx_busy) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    level_d = level_q;
    if (push_c && !pop_c) begin
      level_d = level_q + (ADDR_W+1)'(1);
    end else if (!push_c && pop_c) begin
      level_d = level_q - (ADDR_W+1)'(1);
    end
  end

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      in_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      tx_din_q   <= 8'h00;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      empty_q    <= (level_d == '0);
      full_q     <= (level_d == LEVEL_FULL);
      in_ready_q <= (level_d != LEVEL_FULL);
      wr_en_q    <= (state_d == S_LAUNCH);
      if (push_c) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
        tx_din_q <= mem_q[rd_ptr_q];
      end
    end
  end

  // Storage is deliberately not reset
  always_ff @(posedge clk_50m) begin
    if (push_c) mem_q[wr_ptr_q] <= bus.in_data;
  end

`ifdef UART_TXQ_OVERFLOW_EN
  logic ovf_q;

  // A drop on the same edge as a clear keeps the flag set
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (bus.in_valid && full_q) begin
      ovf_q <= 1'b1;
    end else if (ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

  assign overflow = ovf_q;
`endif

  assign bus.in_ready = in_ready_q;
  assign bus.tx_din   = tx_din_q;
  assign bus.tx_wr_en = wr_en_q;
  assign empty        = empty_q;
  assign full         = full_q;
  assign level        = level_q;

endmodule
